// File: rtl/ofs_plat_axi_mem_rd_arbiter_if.sv
// AR/R bundle between N read requesters and one shared AXI memory sink.
// master drives requests and sink responses; slave is the arbiter side.
interface ofs_plat_axi_mem_rd_arbiter_if #(
   parameter int NUM_SOURCES = 2,
   parameter int ADDR_WIDTH  = 48,
   parameter int DATA_WIDTH  = 512,
   parameter int ID_WIDTH    = 4
);
   localparam int SW = $clog2(NUM_SOURCES);
   localparam int IW = ID_WIDTH + SW;

   logic [NUM_SOURCES-1:0]            src_arvalid;
   logic [NUM_SOURCES-1:0]            src_arready;
   logic [NUM_SOURCES*ID_WIDTH-1:0]   src_arid;
   logic [NUM_SOURCES*ADDR_WIDTH-1:0] src_araddr;
   logic [NUM_SOURCES*8-1:0]          src_arlen;
   logic [NUM_SOURCES-1:0]            src_rvalid;
   logic [NUM_SOURCES-1:0]            src_rready;
   logic [ID_WIDTH-1:0]               src_rid;
   logic [DATA_WIDTH-1:0]             src_rdata;
   logic [1:0]                        src_rresp;
   logic                              src_rlast;

   logic                  snk_arvalid;
   logic                  snk_arready;
   logic [IW-1:0]         snk_arid;
   logic [ADDR_WIDTH-1:0] snk_araddr;
   logic [7:0]            snk_arlen;
   logic                  snk_rvalid;
   logic                  snk_rready;
   logic [IW-1:0]         snk_rid;
   logic [DATA_WIDTH-1:0] snk_rdata;
   logic [1:0]            snk_rresp;
   logic                  snk_rlast;

   modport master (
      output src_arvalid, src_arid, src_araddr, src_arlen, src_rready,
      output snk_arready, snk_rvalid, snk_rid, snk_rdata, snk_rresp,
      output snk_rlast,
      input  src_arready, src_rvalid, src_rid, src_rdata, src_rresp,
      input  src_rlast, snk_arvalid, snk_arid, snk_araddr, snk_arlen,
      input  snk_rready
   );

   modport slave (
      input  src_arvalid, src_arid, src_araddr, src_arlen, src_rready,
      input  snk_arready, snk_rvalid, snk_rid, snk_rdata, snk_rresp,
      input  snk_rlast,
      output src_arready, src_rvalid, src_rid, src_rdata, src_rresp,
      output src_rlast, snk_arvalid, snk_arid, snk_araddr, snk_arlen,
      output snk_rready
   );
endinterface

// File: rtl/ofs_plat_axi_mem_rd_arbiter.sv
// Round-robin AXI read arbiter with per-source burst credits and RID routing.
// Optional grant statistics: define OFS_PLAT_AXI_MEM_RD_ARB_STATS_EN.
module ofs_plat_axi_mem_rd_arbiter #(
   parameter int NUM_SOURCES     = 2,
   parameter int ADDR_WIDTH      = 48,
   parameter int DATA_WIDTH      = 512,
   parameter int ID_WIDTH        = 4,
   parameter int MAX_OUTSTANDING = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   ofs_plat_axi_mem_rd_arbiter_if.slave bus,
   output logic                     err_bad_rid,
   output logic [NUM_SOURCES*32-1:0] stats_grants
);
   localparam int SW = $clog2(NUM_SOURCES);
   localparam int IW = ID_WIDTH + SW;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   logic                  ar_valid_q;
   logic [IW-1:0]         ar_id_q;
   logic [ADDR_WIDTH-1:0] ar_addr_q;
   logic [7:0]            ar_len_q;
   logic [SW-1:0]         rr_ptr_q;
   logic [CW-1:0]         outst_q [NUM_SOURCES];
   logic                  err_q;

   logic [NUM_SOURCES-1:0] elig;
   logic [NUM_SOURCES-1:0] inc;
   logic [NUM_SOURCES-1:0] dec;
   logic                   gnt_vld;
   logic [SW-1:0]          gnt_idx;
   logic                   can_load;
   logic                   grant;
   logic [SW-1:0]          r_idx;
   logic                   r_bad;
   logic                   r_done;
   logic [DATA_WIDTH-1:0]  r_data;

   assign can_load = reset_n && (!ar_valid_q || bus.snk_arready);
   assign grant    = can_load && gnt_vld;

   // A source may request only while it holds a free burst credit
   always_comb begin
      for (int i = 0; i < NUM_SOURCES; i++)
         elig[i] = bus.src_arvalid[i] && (outst_q[i] < CW'(MAX_OUTSTANDING));
   end

   // First eligible source at or after the round-robin pointer
   always_comb begin
      int j;
      j       = 0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NUM_SOURCES; k++) begin
         j = int'(rr_ptr_q) + k;
         if (j >= NUM_SOURCES) j = j - NUM_SOURCES;
         if (!gnt_vld && elig[j]) begin
            gnt_vld = 1'b1;
            gnt_idx = SW'(j);
         end
      end
   end

   // Ready goes only to the winner, only when the AR stage can take it
   always_comb begin
      for (int i = 0; i < NUM_SOURCES; i++)
         inc[i] = grant && (gnt_idx == SW'(i));
   end
   assign bus.src_arready = inc;

   // Single AR stage; reloads under a sink handshake for full throughput
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ar_valid_q <= 1'b0;
         ar_id_q    <= '0;
         ar_addr_q  <= '0;
         ar_len_q   <= '0;
         rr_ptr_q   <= '0;
      end else if (can_load) begin
         ar_valid_q <= gnt_vld;
         if (gnt_vld) begin
            ar_id_q   <= {gnt_idx, bus.src_arid[int'(gnt_idx)*ID_WIDTH +: ID_WIDTH]};
            ar_addr_q <= bus.src_araddr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            ar_len_q  <= bus.src_arlen[int'(gnt_idx)*8 +: 8];
            rr_ptr_q  <= (gnt_idx == SW'(NUM_SOURCES - 1)) ? '0 : gnt_idx + SW'(1);
         end
      end
   end

   assign bus.snk_arvalid = ar_valid_q;
   assign bus.snk_arid    = ar_id_q;
   assign bus.snk_araddr  = ar_addr_q;
   assign bus.snk_arlen   = ar_len_q;

   assign r_idx  = bus.snk_rid[IW-1:ID_WIDTH];
   assign r_bad  = {1'b0, r_idx} >= (SW+1)'(NUM_SOURCES);
   assign r_done = bus.snk_rvalid && bus.snk_rready && bus.snk_rlast && !r_bad;
   assign r_data = bus.snk_rdata;

   // Steer R by the index in the RID; unknown indices are swallowed
   always_comb begin
      bus.src_rvalid = '0;
      bus.snk_rready = r_bad;
      for (int i = 0; i < NUM_SOURCES; i++) begin
         dec[i] = r_done && (r_idx == SW'(i));
         if (!r_bad && (r_idx == SW'(i))) begin
            bus.src_rvalid[i] = bus.snk_rvalid;
            bus.snk_rready    = bus.src_rready[i];
         end
      end
   end

   assign bus.src_rid   = bus.snk_rid[ID_WIDTH-1:0];
   assign bus.src_rdata = r_data;
   assign bus.src_rresp = bus.snk_rresp;
   assign bus.src_rlast = bus.snk_rlast;

   // Burst credits: grant takes one, rlast returns one, both cancel
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_SOURCES; i++) outst_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_SOURCES; i++) begin
            if (inc[i] && !dec[i])
               outst_q[i] <= outst_q[i] + CW'(1);
            else if (dec[i] && !inc[i] && (outst_q[i] != '0))
               outst_q[i] <= outst_q[i] - CW'(1);
         end
      end
   end

   for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_uflow
      a_no_uflow: assert property (@(posedge clk) disable iff (!reset_n)
         !(dec[g] && !inc[g] && (outst_q[g] == '0)));
   end

   // Sticky flag for a response carrying an out-of-range source index
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) err_q <= 1'b0;
      else if (bus.snk_rvalid && r_bad) err_q <= 1'b1;
   end
   assign err_bad_rid = err_q;

`ifdef OFS_PLAT_AXI_MEM_RD_ARB_STATS_EN
   logic [31:0] stats_q [NUM_SOURCES];

   // Free-running per-source grant counters, wrapping at 2^32
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_SOURCES; i++) stats_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_SOURCES; i++)
            if (inc[i]) stats_q[i] <= stats_q[i] + 32'd1;
      end
   end

   // Flatten counters onto the packed stats port
   always_comb begin
      stats_grants = '0;
      for (int i = 0; i < NUM_SOURCES; i++) stats_grants[i*32 +: 32] = stats_q[i];
   end
`else
   assign stats_grants = '0;
`endif
endmodule
